mem_bus: RTL and testbench
==========================

// Module: mem_bus
// PURPOSE
//  Memory/IO bus slave sitting directly downstream of the CPU data port (mem_we/mem_addr/mem_in/mem_out).
//  Decodes each access to word RAM or a small MMIO page: UART TX FIFO + 8N1 serializer, status, optional timer.
//  Reads are combinational (CPU consumes mem_out in the same cycle); all writes and side effects commit on clk rise.
// PARAMETERS
//  RAM_WORDS     4096  16-bit RAM words at 0x0000..RAM_WORDS-1; power of two, <= 0xFF00
//  FIFO_DEPTH    8     TX FIFO entries; power of two, >= 2
//  CLKS_PER_BIT  16    clk cycles per UART bit; >= 2
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  rst_n     in   1   synchronous active-low reset
//  mem_we    in   1   CPU write strobe, sampled on clk rise
//  mem_addr  in   16  CPU word address
//  mem_in    in   16  CPU write data
//  mem_out   out  16  read data, combinational from mem_addr and current state
//  uart_tx   out  1   serial output, idle high
//  tx_irq    out  1   registered; high while FIFO empty and serializer idle
// BEHAVIOUR
//  Reset: one clock (synchronous) with rst_n=0 -> FIFO empty, rd/wr pointers 0, overflow=0, FSM IDLE, uart_tx=1,
//   baud/bit counters 0, timer 0, tx_irq=1 on the first edge after release. RAM contents NOT reset.
//  Reset mid-frame: frame aborted, uart_tx=1 next edge, queued bytes discarded.
//  Map: 0x0000..RAM_WORDS-1 RAM (sync write, async read); 0xFF00 TXDATA; 0xFF01 STATUS; 0xFF02 TIMER.
//   All other addresses: read 0x0000, writes ignored.
//  TXDATA: write pushes mem_in[7:0]; read returns 0x0000, no side effect.
//  STATUS read: [0] full, [1] empty, [2] busy (FSM!=IDLE), [3] overflow, [7:4] fifo count (saturate 15), rest 0.
//   STATUS write: mem_in[3]=1 clears overflow; other bits ignored.
//  FIFO: push when full and no pop same cycle -> byte dropped, overflow<=1 (sticky).
//   Push and pop same cycle when full -> both occur, count unchanged, no overflow.
//   Push into empty FIFO -> popped no earlier than next edge (pop decision uses registered count).
//   Pointers wrap modulo FIFO_DEPTH; count register one bit wider than pointers.
//  Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: if FIFO non-empty, pop into shift reg, go START (uart_tx=0) next edge.
//   START/STOP: hold CLKS_PER_BIT cycles each; STOP drives 1.
//   DATA: 8 bits LSB first, CLKS_PER_BIT each; bit counter 0..7.
//   STOP end: pop next byte directly if non-empty (-> START), else IDLE. Frame = 10*CLKS_PER_BIT cycles.
//   uart_tx registered (no glitches).
//  Latency: TXDATA write at edge N -> uart_tx falls at edge N+2 when idle.
//  Widths: RAM index = mem_addr[$clog2(RAM_WORDS)-1:0] after range check; no aliasing above RAM_WORDS.
// CONFIGURATION
//  MEM_BUS_TIMER_EN defined: 0xFF02 is a free-running 16-bit up-counter, +1 every clk, wraps 0xFFFF->0x0000;
//   read returns current value; write loads mem_in (written value visible next cycle, count resumes from it).
//  Not defined: no counter logic; 0xFF02 reads 0x0000, writes ignored.
// STRUCTURE
//  Package mem_bus_pkg: address constants ADDR_TXDATA/ADDR_STATUS/ADDR_TIMER, STATUS bit indices,
//   typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}.
//  Sub-module tx_fifo (parameterised depth/width, push/pop/full/empty/count); decode, RAM, FSM, timer in mem_bus.
// TESTING
//  1 Reset then write 0xBEEF to 0x0010, read 0x0010 same cycle after edge -> mem_out=0xBEEF; read 0x0010+RAM_WORDS -> 0x0000.
//  2 Write 0x00A5 to 0xFF00 (CLKS_PER_BIT=16) -> uart_tx low 2 edges later; sample mid-bit: 0,1,0,1,0,0,1,0,1,1; tx_irq back to 1 after frame.
//  3 Burst 9 writes 0x01..0x09 back-to-back, depth 8 -> first byte popped after one edge, so 9th accepted, no overflow;
//    10th write 0x0A -> dropped, STATUS[3]=1, STATUS[0]=1; write STATUS with bit3=1 -> STATUS[3]=0.
//  4 Push while FIFO full on the cycle serializer pops (end of STOP) -> count stays 8, overflow stays 0, all bytes emitted in order.
//  5 Assert rst_n=0 for one cycle during DATA bit 4 -> uart_tx=1 next edge, STATUS=0x0002, no further frames.
//  6 MEM_BUS_TIMER_EN: write 0xFFFE to 0xFF02, read after 1 and 3 edges -> 0xFFFF then 0x0001. Without macro: reads 0x0000.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the mem_bus memory/IO slave: MMIO addresses,
// STATUS register bit positions and the UART serializer state encoding.
package mem_bus_pkg;

  // MMIO page addresses
  localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
  localparam logic [15:0] ADDR_STATUS = 16'hFF01;
  localparam logic [15:0] ADDR_TIMER  = 16'hFF02;

  // STATUS register layout
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // FIFO occupancy as shown in STATUS[7:4]; deep FIFOs read as 15.
  function automatic logic [3:0] sat_count4(input logic [15:0] cnt);
    return (cnt > 16'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for the UART transmit path. DEPTH must be a power of two
// so the pointers wrap naturally; count is one bit wider than the pointers so
// that full and empty are distinguishable. A push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is deliberately not reset; validity is tracked by the
  // pointers and count alone, so resetting the array would only cost logic.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus.sv
// Memory/IO bus slave behind the CPU data port. Decodes word RAM at the
// bottom of the map and an MMIO page at 0xFF00: UART TX data, STATUS and an
// optional free-running timer. Reads are combinational; writes and side
// effects commit on the rising clock edge.
// Build option: define MEM_BUS_TIMER_EN to include the timer at 0xFF02;
// without it that address reads 0x0000 and ignores writes.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int RAM_WORDS    = 4096,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_in,
  output logic [15:0] mem_out,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Address decode
  logic ram_sel, txdata_sel, status_sel, timer_sel;
  assign ram_sel    = ({16'h0000, mem_addr} < 32'(RAM_WORDS));
  assign txdata_sel = (mem_addr == ADDR_TXDATA);
  assign status_sel = (mem_addr == ADDR_STATUS);
  assign timer_sel  = (mem_addr == ADDR_TIMER);

  // RAM: synchronous write, asynchronous read, contents survive reset
  logic [15:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  assign ram_idx = mem_addr[RAM_AW-1:0];

  // RAM write port; the range check in ram_sel prevents aliasing.
  always_ff @(posedge clk) begin
    if (mem_we && ram_sel) ram[ram_idx] <= mem_in;
  end

  // TX FIFO
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_rdata;
  logic [FIFO_AW:0]   fifo_count;
  assign fifo_push = mem_we && txdata_sel;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mem_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: set when a byte is dropped, cleared by STATUS write bit 3.
  logic overflow;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (mem_we && status_sel && mem_in[ST_OVF]) begin
      overflow <= 1'b0;
    end
  end

  // Serializer
  tx_state_t         state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              baud_end, tx_bit, busy;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the pop decision sees only the registered FIFO count.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (baud_end) state_nxt = DATA;
      DATA:    if (baud_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (baud_end) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state outputs: FIFO pop strobe and the line level to register.
  always_comb begin
    fifo_pop = 1'b0;
    tx_bit   = 1'b1;
    case (state)
      IDLE:    fifo_pop = !fifo_empty;
      START:   tx_bit   = 1'b0;
      DATA:    tx_bit   = shift_reg[0];
      STOP:    fifo_pop = baud_end && !fifo_empty;
      default: tx_bit   = 1'b1;
    endcase
  end

  // Serializer datapath plus the registered line and interrupt outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
      tx_irq    <= 1'b1;
    end else begin
      uart_tx <= tx_bit;
      tx_irq  <= fifo_empty && (state == IDLE);

      if (fifo_pop)                     shift_reg <= fifo_rdata;
      else if (state == DATA && baud_end) shift_reg <= shift_reg >> 1;

      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;

      if (state != DATA)   bit_cnt <= '0;
      else if (baud_end)   bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Optional timer
  logic [15:0] timer_rdata;
`ifdef MEM_BUS_TIMER_EN
  logic [15:0] timer;

  // Free-running counter; a CPU write reloads it and counting resumes from there.
  always_ff @(posedge clk) begin
    if (!rst_n)                   timer <= 16'h0000;
    else if (mem_we && timer_sel) timer <= mem_in;
    else                          timer <= timer + 16'd1;
  end

  assign timer_rdata = timer;
`else
  assign timer_rdata = 16'h0000;
`endif

  // STATUS word assembly.
  logic [15:0] status_word;
  always_comb begin
    status_word                      = 16'h0000;
    status_word[ST_FULL]             = fifo_full;
    status_word[ST_EMPTY]            = fifo_empty;
    status_word[ST_BUSY]             = busy;
    status_word[ST_OVF]              = overflow;
    status_word[ST_CNT_LSB +: 4]     = sat_count4(16'(fifo_count));
  end

  // Combinational read mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    mem_out = 16'h0000;
    if (ram_sel)         mem_out = ram[ram_idx];
    else if (status_sel) mem_out = status_word;
    else if (timer_sel)  mem_out = timer_rdata;
  end

endmodule

// File: tb/tb_mem_bus.sv
// Scoreboard bench for mem_bus. The driver queues expected read values and
// expected UART bytes; two monitors pop and compare whenever the DUT presents
// a probed read or a complete serial frame.
module tb_mem_bus;
  import mem_bus_pkg::*;

  localparam int RAM_WORDS  = 4096;
  localparam int FIFO_DEPTH = 8;
  localparam int CPB        = 16;

`ifdef MEM_BUS_TIMER_EN
  localparam logic [15:0] TIMER_AFTER_1 = 16'hFFFF;
  localparam logic [15:0] TIMER_AFTER_3 = 16'h0001;
`else
  localparam logic [15:0] TIMER_AFTER_1 = 16'h0000;
  localparam logic [15:0] TIMER_AFTER_3 = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem_in = 16'h0000;
  logic [15:0] mem_out;
  logic        uart_tx;
  logic        tx_irq;

  always #5 clk = ~clk;

  mem_bus #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_out  (mem_out),
    .uart_tx  (uart_tx),
    .tx_irq   (tx_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] data;
    logic        tx;
    logic        irq;
    logic        chk_tx;
    logic        chk_irq;
  } probe_t;

  probe_t     probe_q[$];
  string      probe_name_q[$];
  logic [7:0] tx_q[$];
  logic       probe_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Read monitor: compares the combinational outputs mid-cycle.
  probe_t p_cur;
  string  p_name;
  always @(negedge clk) begin
    if (probe_en) begin
      if (probe_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL probe_underflow: got probe with no expectation expected queued entry");
      end else begin
        p_cur  = probe_q.pop_front();
        p_name = probe_name_q.pop_front();
        check({p_name, "/mem_out"}, mem_out, p_cur.data);
        if (p_cur.chk_tx)  check({p_name, "/uart_tx"}, 16'(uart_tx), 16'(p_cur.tx));
        if (p_cur.chk_irq) check({p_name, "/tx_irq"},  16'(tx_irq),  16'(p_cur.irq));
      end
    end
  end

  // UART monitor: samples each bit near its middle; frames cut by reset are dropped.
  logic [9:0] frame;
  logic [7:0] exp_byte;
  logic       aborted;
  initial begin
    forever begin
      @(negedge uart_tx);
      aborted = 1'b0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < ((b == 0) ? CPB / 2 : CPB); c++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        frame[b] = uart_tx;
      end
      if (!aborted) begin
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL uart_unexpected_frame: got frame 0x%03h expected no frame", frame);
        end else begin
          exp_byte = tx_q.pop_front();
          check("uart_frame", 16'(frame), 16'({1'b1, exp_byte, 1'b0}));
        end
      end
    end
  end

  // Driver helpers
  task automatic idle(input int n);
    mem_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_we   = 1'b1;
    mem_addr = a;
    mem_in   = d;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  task automatic probe(input logic [15:0] a, input logic [15:0] exp, input string name,
                       input logic chk_tx = 1'b0, input logic tx = 1'b0,
                       input logic chk_irq = 1'b0, input logic irq = 1'b0);
    mem_we   = 1'b0;
    mem_addr = a;
    probe_q.push_back('{data: exp, tx: tx, irq: irq, chk_tx: chk_tx, chk_irq: chk_irq});
    probe_name_q.push_back(name);
    probe_en = 1'b1;
    @(posedge clk);
    #1;
    probe_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  int unsigned t2, t5;

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    probe(ADDR_STATUS, 16'h0002, "reset_status", 1'b1, 1'b1, 1'b1, 1'b1);

    // RAM and decode
    wr(16'h0010, 16'hBEEF);
    probe(16'h0010, 16'hBEEF, "ram_rd");
    probe(16'h1010, 16'h0000, "ram_above_range");
    wr(16'h1010, 16'h1234);
    probe(16'h0010, 16'hBEEF, "ram_no_alias");
    probe(16'h0FFF, 16'h0000, "ram_top_before_wr");
    wr(16'h0FFF, 16'h5A5A);
    probe(16'h0FFF, 16'h5A5A, "ram_top");
    probe(16'hFF03, 16'h0000, "unmapped");
    probe(ADDR_TXDATA, 16'h0000, "txdata_rd");
    probe(ADDR_STATUS, 16'h0002, "txdata_rd_no_side_effect");

    // Single byte: latency and frame shape
    wr(ADDR_TXDATA, 16'h00A5);
    tx_q.push_back(8'hA5);
    probe(ADDR_STATUS, 16'h0010, "tx_queued", 1'b1, 1'b1);
    probe(ADDR_STATUS, 16'h0006, "tx_started", 1'b1, 1'b1, 1'b1, 1'b0);
    probe(ADDR_STATUS, 16'h0006, "tx_start_bit", 1'b1, 1'b0);
    idle(165);
    probe(ADDR_STATUS, 16'h0002, "tx_done", 1'b1, 1'b1, 1'b1, 1'b1);

    // Burst: nine accepted, tenth dropped
    for (int i = 1; i <= 10; i++) begin
      wr(ADDR_TXDATA, 16'(i));
      if (i == 2) t2 = cyc;
      if (i <= 9) tx_q.push_back(8'(i));
    end
    probe(ADDR_STATUS, 16'h008D, "burst_overflow");
    wr(ADDR_STATUS, 16'h0008);
    probe(ADDR_STATUS, 16'h0085, "overflow_cleared");

    // Push into full FIFO on the cycle the end of STOP pops
    while (cyc < t2 + 159) begin
      @(posedge clk);
      #1;
    end
    wr(ADDR_TXDATA, 16'h000B);
    tx_q.push_back(8'h0B);
    probe(ADDR_STATUS, 16'h0085, "push_pop_full");
    idle(1500);
    check("tx_queue_drained", 16'(tx_q.size()), 16'h0000);
    probe(ADDR_STATUS, 16'h0002, "burst_done", 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset during data bit 4
    wr(ADDR_TXDATA, 16'h0033);
    t5 = cyc;
    wr(ADDR_TXDATA, 16'h0044);
    while (cyc < t5 + 89) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tx_q.delete();
    probe(ADDR_STATUS, 16'h0002, "mid_frame_reset", 1'b1, 1'b1);
    idle(300);
    probe(ADDR_STATUS, 16'h0002, "post_reset_quiet", 1'b1, 1'b1, 1'b1, 1'b1);

    // Timer
    wr(ADDR_TIMER, 16'hFFFE);
    idle(1);
    probe(ADDR_TIMER, TIMER_AFTER_1, "timer_plus1");
    idle(1);
    probe(ADDR_TIMER, TIMER_AFTER_3, "timer_wrap");

    idle(5);
    check("probe_queue_drained", 16'(probe_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
